// File: rtl/pipe_pkg.sv
// Shared types for the riscv_cpu pipeline controller: FSM states and
// E-stage operand forwarding select encodings.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } ctrl_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for one E-stage ALU operand; M has priority over W
// and x0 is never forwarded.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_wr_en_m,
    input  logic [4:0] rd_w,
    input  logic       reg_wr_en_w,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_wr_en_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            sel = FWD_M;
        end else if (reg_wr_en_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage enables,
// flushes, forwarding, dmem wait with timeout, halt drain and perf counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_wr_en_e,
    input  logic             reg_wr_en_m,
    input  logic             reg_wr_en_w,
    input  logic             load_e,
    input  logic             branch_taken_e,
    input  logic             halt_d,
    input  logic             halt_w,
    input  logic             dmem_req_m,
    input  logic             dmem_ack,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_mw,
    output fwd_sel_t         fwd_a_sel,
    output fwd_sel_t         fwd_b_sel,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t       state_q, state_d;
    ctrl_state_t       ret_q, ret_d;
    ctrl_state_t       eff_state;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              flush_inc;
    logic              load_use;
    logic              mem_wait;

    fwd_unit u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .reg_wr_en_m (reg_wr_en_m),
        .rd_w        (rd_w),
        .reg_wr_en_w (reg_wr_en_w),
        .sel         (fwd_a_sel)
    );

    fwd_unit u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .reg_wr_en_m (reg_wr_en_m),
        .rd_w        (rd_w),
        .reg_wr_en_w (reg_wr_en_w),
        .sel         (fwd_b_sel)
    );

    // reg_wr_en_e is implied by load_e; it is accepted for interface symmetry.
    assign load_use = load_e && (rd_e != 5'd0) &&
                      ((use_rs1_d && (rd_e == rs1_d)) || (use_rs2_d && (rd_e == rs2_d)));
    assign mem_wait = dmem_req_m && !dmem_ack;

    // While waiting on dmem the release cycle behaves as the state we came from.
    assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        flush_inc  = 1'b0;
        en_pc      = 1'b1;
        en_fd      = 1'b1;
        en_de      = 1'b1;
        en_em      = 1'b1;
        en_mw      = 1'b1;
        flush_fd   = 1'b0;
        flush_de   = 1'b0;
        flush_mw   = 1'b0;

        if (state_q == HALTED) begin
            en_pc = 1'b0;
            en_fd = 1'b0;
            en_de = 1'b0;
            en_em = 1'b0;
            en_mw = 1'b0;
        end else if (mem_wait) begin
            en_pc      = 1'b0;
            en_fd      = 1'b0;
            en_de      = 1'b0;
            en_em      = 1'b0;
            flush_mw   = 1'b1;
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                timeout_d = 1'b1;
                state_d   = HALTED;
            end else if (state_q != MEM_WAIT) begin
                ret_d   = state_q;
                state_d = MEM_WAIT;
            end
        end else begin
            wait_cnt_d = '0;
            state_d    = eff_state;
            if (branch_taken_e && (eff_state == RUN || eff_state == DRAIN)) begin
                flush_fd  = 1'b1;
                flush_de  = 1'b1;
                flush_inc = 1'b1;
                state_d   = RUN;
            end else if (eff_state == RUN && load_use) begin
                en_pc    = 1'b0;
                en_fd    = 1'b0;
                flush_de = 1'b1;
            end else if (eff_state == RUN && halt_d) begin
                state_d = DRAIN;
            end else if (eff_state == DRAIN) begin
                en_pc    = 1'b0;
                flush_fd = 1'b1;
                if (halt_w) begin
                    state_d = HALTED;
                end
            end
        end
    end

    always_comb begin
        stall_d     = stall_q;
        flush_cnt_d = flush_cnt_q;
        if (!en_pc && (state_q == RUN || state_q == MEM_WAIT) && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_q     <= stall_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted       = (state_q == HALTED);
    assign timeout_err  = timeout_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; inputs change just after the
// falling edge and outputs are checked 1ns later, well clear of the rising edge.
module tb_pipeline_ctrl;

    import pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        use_rs1_d, use_rs2_d;
    logic        reg_wr_en_e, reg_wr_en_m, reg_wr_en_w;
    logic        load_e, branch_taken_e, halt_d, halt_w, dmem_req_m, dmem_ack;
    logic        en_pc, en_fd, en_de, en_em, en_mw;
    logic        flush_fd, flush_de, flush_mw;
    fwd_sel_t    fwd_a_sel, fwd_b_sel;
    logic        halted, timeout_err;
    logic [31:0] stall_cycles, flush_count;

    int total;
    int bad;

    pipeline_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .use_rs1_d      (use_rs1_d),
        .use_rs2_d      (use_rs2_d),
        .rs1_e          (rs1_e),
        .rs2_e          (rs2_e),
        .rd_e           (rd_e),
        .rd_m           (rd_m),
        .rd_w           (rd_w),
        .reg_wr_en_e    (reg_wr_en_e),
        .reg_wr_en_m    (reg_wr_en_m),
        .reg_wr_en_w    (reg_wr_en_w),
        .load_e         (load_e),
        .branch_taken_e (branch_taken_e),
        .halt_d         (halt_d),
        .halt_w         (halt_w),
        .dmem_req_m     (dmem_req_m),
        .dmem_ack       (dmem_ack),
        .en_pc          (en_pc),
        .en_fd          (en_fd),
        .en_de          (en_de),
        .en_em          (en_em),
        .en_mw          (en_mw),
        .flush_fd       (flush_fd),
        .flush_de       (flush_de),
        .flush_mw       (flush_mw),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .halted         (halted),
        .timeout_err    (timeout_err),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts the failure and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        rs1_d = 0; rs2_d = 0; use_rs1_d = 0; use_rs2_d = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        reg_wr_en_e = 0; reg_wr_en_m = 0; reg_wr_en_w = 0;
        load_e = 0; branch_taken_e = 0; halt_d = 0; halt_w = 0;
        dmem_req_m = 0; dmem_ack = 0;
    endtask

    // Enables are packed {en_pc,en_fd,en_de,en_em,en_mw}, flushes {flush_fd,flush_de,flush_mw}.
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        applyStimulus();
        #1;
        checkOutput("rst_en",    {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);
        checkOutput("rst_flush", {flush_fd, flush_de, flush_mw}, 3'b000);
        checkOutput("rst_fwd",   {fwd_a_sel, fwd_b_sel}, 4'b0000);
        checkOutput("rst_halt",  {halted, timeout_err}, 2'b00);
        checkOutput("rst_stall", stall_cycles, 0);
        checkOutput("rst_flcnt", flush_count, 0);
        @(negedge clk); rst = 1'b1;

        // Forwarding: M beats W, x0 never forwards, W when M not writing
        @(negedge clk);
        rs1_e = 5; rs2_e = 9; rd_m = 5; reg_wr_en_m = 1; rd_w = 5; reg_wr_en_w = 1;
        #1 checkOutput("fwd_a_m", fwd_a_sel, FWD_M);
        checkOutput("fwd_b_none", fwd_b_sel, FWD_RF);
        @(negedge clk); rs1_e = 0; rd_m = 0;
        #1 checkOutput("fwd_a_x0", fwd_a_sel, FWD_RF);
        @(negedge clk); rs1_e = 5; rd_m = 5; reg_wr_en_m = 0; rs2_e = 5;
        #1 checkOutput("fwd_a_w", fwd_a_sel, FWD_W);
        checkOutput("fwd_b_w", fwd_b_sel, FWD_W);
        @(negedge clk); rs2_e = 0; rd_w = 0; rd_m = 0; reg_wr_en_m = 1;
        #1 checkOutput("fwd_b_x0", fwd_b_sel, FWD_RF);

        // Load-use near misses must not stall
        @(negedge clk); applyStimulus();
        load_e = 1; rd_e = 7; rs2_d = 7; use_rs2_d = 0; rs1_d = 3; use_rs1_d = 1;
        #1 checkOutput("lu_nouse_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);
        @(negedge clk); rd_e = 0; rs1_d = 0; use_rs1_d = 1;
        #1 checkOutput("lu_x0_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);

        // Real load-use hit for one cycle
        @(negedge clk); applyStimulus();
        load_e = 1; rd_e = 7; rs2_d = 7; use_rs2_d = 1;
        #1 checkOutput("lu_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b00111);
        checkOutput("lu_flush", {flush_fd, flush_de, flush_mw}, 3'b010);
        @(negedge clk); applyStimulus();
        #1 checkOutput("lu_after_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);
        checkOutput("lu_stall", stall_cycles, 1);

        // Taken branch wins over load-use
        @(negedge clk);
        load_e = 1; rd_e = 7; rs2_d = 7; use_rs2_d = 1; branch_taken_e = 1;
        #1 checkOutput("br_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);
        checkOutput("br_flush", {flush_fd, flush_de, flush_mw}, 3'b110);
        @(negedge clk); applyStimulus();
        #1 checkOutput("br_flcnt", flush_count, 1);
        checkOutput("br_stall", stall_cycles, 1);

        // Memory wait: three wait cycles (branch in the middle is suppressed), then ack
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_req_m = 1; dmem_ack = 0; branch_taken_e = (i == 1);
            #1 checkOutput("mw_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b00001);
            checkOutput("mw_flush", {flush_fd, flush_de, flush_mw}, 3'b001);
        end
        @(negedge clk); branch_taken_e = 0; dmem_ack = 1;
        #1 checkOutput("mw_ack_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);
        checkOutput("mw_ack_flush", {flush_fd, flush_de, flush_mw}, 3'b000);
        @(negedge clk); applyStimulus();
        #1 checkOutput("mw_run_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);
        checkOutput("mw_stall", stall_cycles, 4);
        checkOutput("mw_flcnt", flush_count, 1);

        // Memory timeout: 16 unacknowledged cycles, halted from the 17th
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); dmem_req_m = 1; dmem_ack = 0;
            #1 checkOutput("to_wait_halt", {halted, timeout_err}, 2'b00);
        end
        @(negedge clk); applyStimulus(); branch_taken_e = 1;
        #1 checkOutput("to_flags", {halted, timeout_err}, 2'b11);
        checkOutput("to_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b00000);
        checkOutput("to_flush", {flush_fd, flush_de, flush_mw}, 3'b000);
        checkOutput("to_stall", stall_cycles, 20);
        @(negedge clk); applyStimulus(); rst = 1'b0;
        #1 checkOutput("to_rst_flags", {halted, timeout_err}, 2'b00);
        checkOutput("to_rst_stall", stall_cycles, 0);
        @(negedge clk); rst = 1'b1;

        // Halt drain: halt_d, three drain cycles with halt_w on the third, then halted
        @(negedge clk); halt_d = 1;
        #1 checkOutput("hd_entry_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); halt_d = 0; halt_w = (i == 2);
            #1 checkOutput("hd_drain_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b01111);
            checkOutput("hd_drain_flush", {flush_fd, flush_de, flush_mw}, 3'b100);
            checkOutput("hd_drain_halt", halted, 0);
        end
        @(negedge clk); applyStimulus();
        #1 checkOutput("hd_halted", halted, 1);
        checkOutput("hd_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b00000);
        checkOutput("hd_stall", stall_cycles, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Halt on the wrong path: branch during drain returns to RUN
        @(negedge clk); halt_d = 1;
        @(negedge clk); halt_d = 0; branch_taken_e = 1;
        #1 checkOutput("hb_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);
        checkOutput("hb_flush", {flush_fd, flush_de, flush_mw}, 3'b110);
        @(negedge clk); applyStimulus();
        #1 checkOutput("hb_run_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b11111);
        checkOutput("hb_run_flush", {flush_fd, flush_de, flush_mw}, 3'b000);
        checkOutput("hb_flcnt", flush_count, 1);
        halt_w = 1;
        @(negedge clk); applyStimulus();
        #1 checkOutput("hb_not_halted", halted, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
